spi_ll_arbiter: RTL

- Shares one low-level SPI byte engine between NREQ requesters: command engine, block-write data engine, block-read data engine.
- Grants the byte stream to one requester for a whole transaction, with round-robin fairness.
- Masks all other requesters with busy while a grant is held.
- Routes returned SPI bytes only to the granted requester.
- Inserts a guaranteed idle gap between owners.

---
 rtl/spi_ll_arbiter.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/spi_ll_arbiter.sv
// rtl/spi_ll_arbiter.sv - round-robin owner arbiter sharing one SPI byte engine between NREQ requesters
//
// Grants the SPI byte stream to one requester for a whole transaction (i_req held high),
// masks everyone else with busy, routes returned bytes to the owner, and enforces an idle
// gap of GAP non-busy engine cycles before the grant is released.
//
// Optional watchdog: define ARB_TIMEOUT_EN to build it; otherwise o_timeout is tied low.
//
// Ports:
//   i_clk, i_reset      clock, synchronous active-high reset
//   i_req[NREQ]         per-requester ownership request
//   i_stb[NREQ]         per-requester byte strobe
//   i_byte[8*NREQ]      per-requester byte, requester k on [8k+7:8k]
//   o_busy[NREQ]        per-requester busy (inverse ready)
//   o_grant[NREQ]       one-hot-or-zero current owner
//   o_rxstb[NREQ]       per-requester received-byte strobe
//   o_rxbyte[8]         received byte, shared
//   o_ll_stb, o_ll_byte byte strobe/data to the SPI engine
//   i_ll_busy           SPI engine busy
//   i_ll_stb, i_ll_byte SPI engine received byte
//   o_timeout           one-cycle watchdog pulse
module spi_ll_arbiter #(
  parameter int NREQ    = 3,
  parameter int GAP     = 2,
  parameter int TIMEOUT = 4096
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic [NREQ-1:0]   i_req,
  input  logic [NREQ-1:0]   i_stb,
  input  logic [8*NREQ-1:0] i_byte,
  output logic [NREQ-1:0]   o_busy,
  output logic [NREQ-1:0]   o_grant,
  output logic [NREQ-1:0]   o_rxstb,
  output logic [7:0]        o_rxbyte,
  output logic              o_ll_stb,
  output logic [7:0]        o_ll_byte,
  input  logic              i_ll_busy,
  input  logic              i_ll_stb,
  input  logic [7:0]        i_ll_byte,
  output logic              o_timeout
);
  localparam int RRW = $clog2(NREQ);
  localparam int GW  = $clog2(GAP + 1) + 1;

  typedef enum logic [1:0] {IDLE, GRANTED, DRAIN} state_t;

  state_t          r_state, w_state_nxt;
  logic [NREQ-1:0] r_grant, w_grant_nxt;
  logic [RRW-1:0]  r_rr, w_rr_nxt;
  logic [RRW-1:0]  r_owner, w_owner_nxt;
  logic [GW-1:0]   r_gap, w_gap_nxt;
  logic [NREQ-1:0] w_req_m;
  logic [RRW-1:0]  w_pick;
  logic [RRW:0]    w_dist, w_best;
  logic            w_found;
  logic            w_owner_req;
  logic            w_owner_stb;
  logic            w_gap_done;
  logic            w_wd_hit;

  // Round-robin pick: the requesting index with the smallest distance (k - rr) mod NREQ.
  always_comb begin
    w_found = 1'b0;
    w_pick  = '0;
    w_best  = '1;
    w_dist  = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (RRW'(k) >= r_rr) w_dist = (RRW+1)'(k) - {1'b0, r_rr};
      else                 w_dist = (RRW+1)'(k + NREQ) - {1'b0, r_rr};
      if (w_req_m[k] && (!w_found || (w_dist < w_best))) begin
        w_found = 1'b1;
        w_best  = w_dist;
        w_pick  = RRW'(k);
      end
    end
  end

  // Owner-side mux: request, strobe and byte of the granted index; busy to everyone else.
  always_comb begin
    w_owner_req = 1'b0;
    w_owner_stb = 1'b0;
    o_ll_byte   = 8'hff;
    o_busy      = '1;
    for (int k = 0; k < NREQ; k++) begin
      if (r_grant[k]) begin
        w_owner_req = i_req[k];
        w_owner_stb = i_stb[k];
        o_ll_byte   = i_byte[8*k +: 8];
        if (r_state == GRANTED) o_busy[k] = i_ll_busy;
      end
    end
  end

  assign o_ll_stb  = (r_state == GRANTED) && w_owner_stb;
  assign o_grant   = r_grant;
  assign o_rxstb   = r_grant & {NREQ{i_ll_stb}};
  assign o_rxbyte  = i_ll_byte;

  // The current DRAIN cycle is the GAP-th consecutive non-busy one.
  assign w_gap_done = !i_ll_busy && ((int'(r_gap) + 1) >= GAP);

  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    w_owner_nxt = r_owner;
    w_rr_nxt    = r_rr;
    w_gap_nxt   = '0;
    case (r_state)
      IDLE: begin
        if (w_found) begin
          w_state_nxt = GRANTED;
          w_grant_nxt = NREQ'(1) << w_pick;
          w_owner_nxt = w_pick;
        end
      end
      GRANTED: begin
        if (!w_owner_req || w_wd_hit) w_state_nxt = DRAIN;
      end
      DRAIN: begin
        if (w_gap_done) begin
          w_state_nxt = IDLE;
          w_grant_nxt = '0;
          w_rr_nxt    = (r_owner == RRW'(NREQ-1)) ? '0 : r_owner + 1'b1;
        end else if (!i_ll_busy) begin
          w_gap_nxt = r_gap + 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= IDLE;
      r_grant <= '0;
      r_rr    <= '0;
      r_owner <= '0;
      r_gap   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_grant <= w_grant_nxt;
      r_rr    <= w_rr_nxt;
      r_owner <= w_owner_nxt;
      r_gap   <= w_gap_nxt;
    end
  end

`ifdef ARB_TIMEOUT_EN
  localparam int WW = $clog2(TIMEOUT);

  logic [WW-1:0]   r_wd;
  logic [NREQ-1:0] r_mask;
  logic            r_timeout;
  logic            w_activity;

  assign w_activity = (o_ll_stb && !i_ll_busy) || i_ll_stb;
  // A requester that drops i_req on the limit cycle drains normally instead of timing out.
  assign w_wd_hit   = (r_state == GRANTED) && w_owner_req && !w_activity &&
                      (r_wd == WW'(TIMEOUT-1));
  assign w_req_m    = i_req & ~r_mask;
  assign o_timeout  = r_timeout;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_wd      <= '0;
      r_mask    <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_timeout <= w_wd_hit;
      if ((r_state != GRANTED) || w_activity || w_wd_hit) r_wd <= '0;
      else                                                r_wd <= r_wd + 1'b1;
      // Timed-out owner stays masked until its request is seen low.
      r_mask <= (r_mask | (w_wd_hit ? r_grant : '0)) & i_req;
    end
  end
`else
  assign w_wd_hit  = 1'b0;
  assign w_req_m   = i_req;
  assign o_timeout = 1'b0;
`endif

endmodule
